// File: rtl/r16_pipe_delay_unit.sv
// -----------------------------------------------------------------------------
// r16_pipe_delay_unit
//
// Purpose:
//   Configurable pipeline delay stage for the radix-16 FFT datapath. It sits
//   between the butterfly/twiddle stages and the modular multiplier and
//   delays two lanes by independent depths so that each one reaches its
//   consumer stage aligned:
//     - data lane {valid, Ac, A0}, DATA_DLY stages deep, carries a valid bit
//     - side lane Ninv2, SIDE_DLY stages deep, carries no valid bit
//   It also keeps a frame position index (FRAME_LEN samples per frame) and
//   flags the final sample of each frame on out_last.
//
// Parameters:
//   P_WIDTH   data lane width (the side lane is P_WIDTH+1 bits)
//   DATA_DLY  data-lane latency in enabled cycles (1..8)
//   SIDE_DLY  side-lane latency in enabled cycles (1..8)
//   FRAME_LEN samples per frame, power of two (2..256)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         advance enable; 0 holds every stage, the index and frame_cnt
//   flush      synchronous clear of all valid bits and the sample index
//   in_valid   qualifier for A0_in/Ac_in
//   A0_in      data lane input
//   Ac_in      carry/flag travelling with A0_in
//   Ninv2_in   side lane input (unqualified)
//   A0_out     data lane after DATA_DLY enabled cycles
//   Ac_out     carry after DATA_DLY enabled cycles
//   out_valid  valid after DATA_DLY enabled cycles
//   out_last   out_valid on the final sample of a frame
//   Ninv2_out  side lane after SIDE_DLY enabled cycles
//   frame_cnt  completed-frame count
//
// Build option:
//   R16_PIPE_STAT_EN  when defined, frame_cnt counts completed frames
//                     (saturating, cleared only by rst_n). When undefined,
//                     frame_cnt is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module r16_pipe_delay_unit #(
  parameter int P_WIDTH   = 64,
  parameter int DATA_DLY  = 1,
  parameter int SIDE_DLY  = 2,
  parameter int FRAME_LEN = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [P_WIDTH-1:0] A0_in,
  input  logic               Ac_in,
  input  logic [P_WIDTH:0]   Ninv2_in,
  output logic [P_WIDTH-1:0] A0_out,
  output logic               Ac_out,
  output logic               out_valid,
  output logic               out_last,
  output logic [P_WIDTH:0]   Ninv2_out,
  output logic [15:0]        frame_cnt
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  // Delay stages; index 0 is loaded from the inputs, the last index drives
  // the outputs directly.
  logic [P_WIDTH-1:0] a0_r    [DATA_DLY];
  logic               ac_r    [DATA_DLY];
  logic               valid_r [DATA_DLY];
  logic [P_WIDTH:0]   side_r  [SIDE_DLY];
  logic [IDX_W-1:0]   idx_r;
  logic               advance_s;

  // Data-lane payload shift; flush leaves the payload alone and only the
  // valid bits below are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_DLY; i++) begin
        a0_r[i] <= '0;
        ac_r[i] <= 1'b0;
      end
    end else if (en) begin
      a0_r[0] <= A0_in;
      ac_r[0] <= Ac_in;
      for (int i = 1; i < DATA_DLY; i++) begin
        a0_r[i] <= a0_r[i-1];
        ac_r[i] <= ac_r[i-1];
      end
    end
  end

  // Data-lane valid shift; flush wins over en, so a sample offered together
  // with flush is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_DLY; i++) begin
        valid_r[i] <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < DATA_DLY; i++) begin
        valid_r[i] <= 1'b0;
      end
    end else if (en) begin
      valid_r[0] <= in_valid;
      for (int i = 1; i < DATA_DLY; i++) begin
        valid_r[i] <= valid_r[i-1];
      end
    end
  end

  // Side-lane shift; unqualified, moves on every enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIDE_DLY; i++) begin
        side_r[i] <= '0;
      end
    end else if (en) begin
      side_r[0] <= Ninv2_in;
      for (int i = 1; i < SIDE_DLY; i++) begin
        side_r[i] <= side_r[i-1];
      end
    end
  end

  assign A0_out    = a0_r[DATA_DLY-1];
  assign Ac_out    = ac_r[DATA_DLY-1];
  assign out_valid = valid_r[DATA_DLY-1];
  assign Ninv2_out = side_r[SIDE_DLY-1];

  // An output sample is consumed when it is valid and the pipe advances.
  assign advance_s = out_valid & en & ~flush;

  // Frame position of the sample currently on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= '0;
    end else if (flush) begin
      idx_r <= '0;
    end else if (advance_s) begin
      if (idx_r == IDX_LAST) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end
  end

  // Gated by out_valid so a bubble parked at the last index never flags.
  assign out_last = out_valid & (idx_r == IDX_LAST);

`ifdef R16_PIPE_STAT_EN
  logic [15:0] frame_cnt_r;

  // Completed-frame counter, saturating; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 16'h0000;
    end else if (out_last && en && !flush && (frame_cnt_r != 16'hFFFF)) begin
      frame_cnt_r <= frame_cnt_r + 16'h0001;
    end
  end

  assign frame_cnt = frame_cnt_r;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_r16_pipe_delay_unit.sv
// -----------------------------------------------------------------------------
// Testbench for r16_pipe_delay_unit: a default-parameter instance plus a
// DATA_DLY=3 / SIDE_DLY=1 instance sharing the same stimulus. A directed
// vector table covers latency, stall, bubble and flush behaviour; hand-written
// sequences cover frame boundaries, flush recovery, frame counting and
// asynchronous reset.
// -----------------------------------------------------------------------------
module tb_r16_pipe_delay_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic [63:0] A0_in;
  logic        Ac_in;
  logic [64:0] Ninv2_in;

  logic [63:0] a0_d;
  logic        ac_d;
  logic        valid_d;
  logic        last_d;
  logic [64:0] n2_d;
  logic [15:0] fc_d;

  logic [63:0] a0_3;
  logic        ac_3;
  logic        valid_3;
  logic        last_3;
  logic [64:0] n2_3;
  logic [15:0] fc_3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  r16_pipe_delay_unit u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .A0_in(A0_in), .Ac_in(Ac_in), .Ninv2_in(Ninv2_in),
    .A0_out(a0_d), .Ac_out(ac_d), .out_valid(valid_d), .out_last(last_d),
    .Ninv2_out(n2_d), .frame_cnt(fc_d)
  );

  r16_pipe_delay_unit #(.P_WIDTH(64), .DATA_DLY(3), .SIDE_DLY(1), .FRAME_LEN(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .A0_in(A0_in), .Ac_in(Ac_in), .Ninv2_in(Ninv2_in),
    .A0_out(a0_3), .Ac_out(ac_3), .out_valid(valid_3), .out_last(last_3),
    .Ninv2_out(n2_3), .frame_cnt(fc_3)
  );

  typedef struct {
    logic        en;
    logic        fl;
    logic        iv;
    logic [63:0] a0;
    logic        ac;
    logic [64:0] n2;
    logic        ev;
    logic [63:0] ea0;
    logic        eac;
    logic        el;
    logic [64:0] en2;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic f, input logic v,
                       input logic [63:0] a, input logic c, input logic [64:0] n);
    en = e; flush = f; in_valid = v; A0_in = a; Ac_in = c; Ninv2_in = n;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 65'h0);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  // Streams 16 valid samples; out_last must rise only on the 16th.
  task automatic stream_frame(input string tag);
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, 1'b0, 1'b1, 64'(j + 100), 1'b0, 65'h5);
      tick();
      chk($sformatf("%s_valid%0d", tag, j), 128'(valid_d), 128'(1'b1));
      chk($sformatf("%s_last%0d", tag, j), 128'(last_d), 128'(j == 15));
    end
  endtask

  initial begin
    logic [15:0] exp_fc;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 65'h0);
    #2;
    // Reset state.
    chk("rst_a0", 128'(a0_d), 128'h0);
    chk("rst_valid", 128'(valid_d), 128'h0);
    chk("rst_n2", 128'(n2_d), 128'h0);
    chk("rst_fc", 128'(fc_d), 128'h0);
    chk("rst_valid3", 128'(valid_3), 128'h0);
    #6;
    rst_n = 1'b1;

    //           en    fl    iv    a0      ac    n2                         ev    ea0     eac   el    en2
    tbl[0] = '{1'b1, 1'b0, 1'b1, 64'h1, 1'b1, 65'h1_0000_0000_0000_0005, 1'b1, 64'h1, 1'b1, 1'b0, 65'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 64'h2, 1'b0, 65'h1_0000_0000_0000_0005, 1'b1, 64'h2, 1'b0, 1'b0, 65'h1_0000_0000_0000_0005};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 64'h3, 1'b1, 65'h7,                     1'b1, 64'h3, 1'b1, 1'b0, 65'h1_0000_0000_0000_0005};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 64'h4, 1'b0, 65'h9,                     1'b1, 64'h3, 1'b1, 1'b0, 65'h1_0000_0000_0000_0005};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 64'h5, 1'b0, 65'h9,                     1'b0, 64'h0, 1'b0, 1'b0, 65'h7};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 64'h6, 1'b0, 65'hA,                     1'b1, 64'h6, 1'b0, 1'b0, 65'h9};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 64'h7, 1'b1, 65'hB,                     1'b0, 64'h0, 1'b0, 1'b0, 65'h9};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 64'h8, 1'b1, 65'hC,                     1'b1, 64'h8, 1'b1, 1'b0, 65'hA};

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].en, tbl[i].fl, tbl[i].iv, tbl[i].a0, tbl[i].ac, tbl[i].n2);
      tick();
      chk($sformatf("vec%0d_valid", i), 128'(valid_d), 128'(tbl[i].ev));
      chk($sformatf("vec%0d_last", i), 128'(last_d), 128'(tbl[i].el));
      chk($sformatf("vec%0d_n2", i), 128'(n2_d), 128'(tbl[i].en2));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_a0", i), 128'(a0_d), 128'(tbl[i].ea0));
        chk($sformatf("vec%0d_ac", i), 128'(ac_d), 128'(tbl[i].eac));
      end
    end

    // Deep lane: latency counts enabled edges only.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 64'h10, 1'b1, 65'h33);
    tick();
    chk("d3_e1_valid", 128'(valid_3), 128'h0);
    chk("d3_e1_n2", 128'(n2_3), 128'h33);
    drive(1'b0, 1'b0, 1'b0, 64'h99, 1'b0, 65'h44);
    tick();
    chk("d3_stall_valid", 128'(valid_3), 128'h0);
    chk("d3_stall_n2", 128'(n2_3), 128'h33);
    drive(1'b1, 1'b0, 1'b0, 64'h99, 1'b0, 65'h44);
    tick();
    chk("d3_e2_valid", 128'(valid_3), 128'h0);
    tick();
    chk("d3_e3_valid", 128'(valid_3), 128'h1);
    chk("d3_e3_a0", 128'(a0_3), 128'h10);
    chk("d3_e3_ac", 128'(ac_3), 128'h1);
    drive(1'b0, 1'b0, 1'b0, 64'h99, 1'b0, 65'h44);
    tick();
    chk("d3_hold_valid", 128'(valid_3), 128'h1);
    chk("d3_hold_a0", 128'(a0_3), 128'h10);

    // Frame boundary, bubble, and restart at index 0.
    do_reset();
    stream_frame("frA");
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 65'h5);
    tick();
    chk("bubble_valid", 128'(valid_d), 128'h0);
    chk("bubble_last", 128'(last_d), 128'h0);
    stream_frame("frB");

    // Flush mid-frame with a simultaneous valid input.
    do_reset();
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 1'b0, 1'b1, 64'(j), 1'b0, 65'h5);
      tick();
    end
    chk("preflush_valid3", 128'(valid_3), 128'h1);
    drive(1'b1, 1'b1, 1'b1, 64'hEE, 1'b0, 65'h5);
    tick();
    chk("flush_valid", 128'(valid_d), 128'h0);
    chk("flush_last", 128'(last_d), 128'h0);
    chk("flush_valid3_0", 128'(valid_3), 128'h0);
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, 1'b0, 1'b1, 64'(j + 200), 1'b0, 65'h5);
      tick();
      chk($sformatf("flr_valid%0d", j), 128'(valid_d), 128'h1);
      chk($sformatf("flr_last%0d", j), 128'(last_d), 128'(j == 15));
      if (j < 2) begin
        chk($sformatf("flr_valid3_%0d", j + 1), 128'(valid_3), 128'h0);
      end else if (j == 2) begin
        chk("flr_valid3_on", 128'(valid_3), 128'h1);
        chk("flr_a0_3", 128'(a0_3), 128'd200);
      end
    end

    // Three full frames, then count check.
    do_reset();
    for (int j = 0; j < 48; j++) begin
      drive(1'b1, 1'b0, 1'b1, 64'(j), 1'b1, 65'h1_2345);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 65'h1_2345);
    tick();
`ifdef R16_PIPE_STAT_EN
    exp_fc = 16'd3;
`else
    exp_fc = 16'd0;
`endif
    chk("frame_cnt3", 128'(fc_d), 128'(exp_fc));

    // Asynchronous reset between edges, mid-frame with out_valid high.
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, 1'b0, 1'b1, 64'hABCD, 1'b1, 65'h1_2345);
      tick();
    end
    chk("prerst_valid", 128'(valid_d), 128'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a0", 128'(a0_d), 128'h0);
    chk("arst_ac", 128'(ac_d), 128'h0);
    chk("arst_n2", 128'(n2_d), 128'h0);
    chk("arst_valid", 128'(valid_d), 128'h0);
    chk("arst_last", 128'(last_d), 128'h0);
    chk("arst_fc", 128'(fc_d), 128'h0);
    chk("arst_a0_3", 128'(a0_3), 128'h0);
    #1;
    rst_n = 1'b1;
    stream_frame("frR");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
